// File: rtl/syn_fifo_wr_arb.sv
// Round-robin burst arbiter that lets two producers share one FIFO write port.
// Optional stall counter output enabled by SYN_FIFO_WR_ARB_STALL_CNT_EN.
module syn_fifo_wr_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_0,
    input  logic [DATA_WIDTH-1:0] data_0,
    input  logic                  req_1,
    input  logic [DATA_WIDTH-1:0] data_1,
    input  logic                  fifo_full,
    output logic                  gnt_0,
    output logic                  gnt_1,
    output logic                  acc_0,
    output logic                  acc_1,
    output logic                  fifo_wr_cs,
    output logic                  fifo_wr_en,
`ifdef SYN_FIFO_WR_ARB_STALL_CNT_EN
    output logic [15:0]           stall_cnt,
`endif
    output logic [DATA_WIDTH-1:0] fifo_data
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    state_t     state;
    logic       last_owner;
    logic [7:0] beat_cnt;
    logic       burst_done;

    assign acc_0      = gnt_0 & req_0 & ~fifo_full & ~rst;
    assign acc_1      = gnt_1 & req_1 & ~fifo_full & ~rst;
    assign fifo_wr_cs = acc_0 | acc_1;
    assign fifo_wr_en = acc_0 | acc_1;
    assign burst_done = (acc_0 | acc_1) && (beat_cnt == LAST_BEAT);

    always_comb begin
        fifo_data = '0;
        if (!rst)
            fifo_data = gnt_1 ? data_1 : data_0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gnt_0      <= 1'b0;
            gnt_1      <= 1'b0;
            last_owner <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // last_owner breaks the tie when both are requesting
                    if (req_0 && (!req_1 || last_owner)) begin
                        state <= OWN0;
                        gnt_0 <= 1'b1;
                    end else if (req_1) begin
                        state <= OWN1;
                        gnt_1 <= 1'b1;
                    end
                end
                OWN0: begin
                    if (!req_0 || burst_done) begin
                        last_owner <= 1'b0;
                        beat_cnt   <= '0;
                        if (req_1) begin
                            state <= OWN1;
                            gnt_0 <= 1'b0;
                            gnt_1 <= 1'b1;
                        end else if (!req_0) begin
                            state <= IDLE;
                            gnt_0 <= 1'b0;
                        end
                    end else if (acc_0) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                end
                OWN1: begin
                    if (!req_1 || burst_done) begin
                        last_owner <= 1'b1;
                        beat_cnt   <= '0;
                        if (req_0) begin
                            state <= OWN0;
                            gnt_1 <= 1'b0;
                            gnt_0 <= 1'b1;
                        end else if (!req_1) begin
                            state <= IDLE;
                            gnt_1 <= 1'b0;
                        end
                    end else if (acc_1) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_0 <= 1'b0;
                    gnt_1 <= 1'b0;
                end
            endcase
        end
    end

`ifdef SYN_FIFO_WR_ARB_STALL_CNT_EN
    logic stalled;
    assign stalled = ((gnt_0 & req_0) | (gnt_1 & req_1)) & fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stalled && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_syn_fifo_wr_arb.sv
// Bench for syn_fifo_wr_arb: BURST_LEN=4 and BURST_LEN=1 instances share stimulus
// and are checked against a queue-free ownership model plus directed literals.
module tb_syn_fifo_wr_arb;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_0 = 1'b0;
    logic       req_1 = 1'b0;
    logic       fifo_full = 1'b0;
    logic [7:0] data_0 = 8'h00;
    logic [7:0] data_1 = 8'h00;

    logic [1:0] g0, g1, a0, a1, cs, en;
    logic [7:0] fd [2];
`ifdef SYN_FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0] sc [2];
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // model: owner -1 none, 0/1 producer; beats taken in current grant
    int owner [2];
    int beats [2];
    int last  [2];
    int stall [2];

    syn_fifo_wr_arb #(.DATA_WIDTH(8), .BURST_LEN(4)) u_b4 (
        .clk(clk), .rst(rst),
        .req_0(req_0), .data_0(data_0),
        .req_1(req_1), .data_1(data_1),
        .fifo_full(fifo_full),
        .gnt_0(g0[0]), .gnt_1(g1[0]),
        .acc_0(a0[0]), .acc_1(a1[0]),
        .fifo_wr_cs(cs[0]), .fifo_wr_en(en[0]),
`ifdef SYN_FIFO_WR_ARB_STALL_CNT_EN
        .stall_cnt(sc[0]),
`endif
        .fifo_data(fd[0])
    );

    syn_fifo_wr_arb #(.DATA_WIDTH(8), .BURST_LEN(1)) u_b1 (
        .clk(clk), .rst(rst),
        .req_0(req_0), .data_0(data_0),
        .req_1(req_1), .data_1(data_1),
        .fifo_full(fifo_full),
        .gnt_0(g0[1]), .gnt_1(g1[1]),
        .acc_0(a0[1]), .acc_1(a1[1]),
        .fifo_wr_cs(cs[1]), .fifo_wr_en(en[1]),
`ifdef SYN_FIFO_WR_ARB_STALL_CNT_EN
        .stall_cnt(sc[1]),
`endif
        .fifo_data(fd[1])
    );

    always #5 clk = ~clk;

    function automatic int blen(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic check(input string name, input int k,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s inst%0d: got %h expected %h at %0t",
                     name, k, act, exp, $time);
    endtask

    function automatic void mreset(input int k);
        owner[k] = -1;
        beats[k] = 0;
        last[k]  = 1;
        stall[k] = 0;
    endfunction

    function automatic void mstep(input int k);
        logic rq [2];
        int   x, o;
        logic acc;
        rq[0] = req_0;
        rq[1] = req_1;
        if (owner[k] >= 0 && rq[owner[k]] && fifo_full && stall[k] < 65535)
            stall[k]++;
        if (owner[k] < 0) begin
            if (req_0 && req_1) owner[k] = 1 - last[k];
            else if (req_0)     owner[k] = 0;
            else if (req_1)     owner[k] = 1;
        end else begin
            x   = owner[k];
            o   = 1 - x;
            acc = rq[x] && !fifo_full;
            if (!rq[x] || (acc && beats[k] == blen(k) - 1)) begin
                last[k]  = x;
                beats[k] = 0;
                if (rq[o])      owner[k] = o;
                else if (rq[x]) owner[k] = x;
                else            owner[k] = -1;
            end else if (acc) begin
                beats[k]++;
            end
        end
    endfunction

    function automatic logic [31:0] expect_out(input int k);
        logic e0, e1, ea0, ea1;
        logic [7:0] d;
        e0  = (owner[k] == 0);
        e1  = (owner[k] == 1);
        ea0 = e0 && req_0 && !fifo_full && !rst;
        ea1 = e1 && req_1 && !fifo_full && !rst;
        d   = rst ? 8'h00 : (e1 ? data_1 : data_0);
        return {18'd0, e0, e1, ea0, ea1, ea0 | ea1, ea0 | ea1, d};
    endfunction

    initial begin
        mreset(0);
        mreset(1);
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) mreset(k);
            else     mstep(k);
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) mreset(k);
            check("model_outputs", k,
                  {18'd0, g0[k], g1[k], a0[k], a1[k], cs[k], en[k], fd[k]},
                  expect_out(k));
`ifdef SYN_FIFO_WR_ARB_STALL_CNT_EN
            check("model_stall_cnt", k, {16'd0, sc[k]}, stall[k]);
`endif
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        // reset held with both requesting
        rst = 1'b1; req_0 = 1'b1; req_1 = 1'b1;
        data_0 = 8'h11; data_1 = 8'h22;
        #1;
        for (int i = 0; i < 3; i++) begin
            mid();
            check("rst_gnt", 0, {30'd0, g0}, 32'd0);
            check("rst_gnt1", 0, {30'd0, g1}, 32'd0);
            check("rst_wr_en", 0, {30'd0, en}, 32'd0);
            nxt();
        end
        rst = 1'b0;
        mid();
        check("idle_after_rst", 0, {30'd0, g0}, 32'd0);
        nxt();
        // fairness stream: 4-beat bursts vs strict alternation
        for (int i = 0; i < 12; i++) begin
            mid();
            check("fair_en_b4", 0, {31'd0, en[0]}, 32'd1);
            check("fair_gnt0_b4", 0, {31'd0, g0[0]}, ((i / 4) % 2 == 0) ? 1 : 0);
            check("fair_data_b4", 0, {24'd0, fd[0]},
                  ((i / 4) % 2 == 1) ? 32'h22 : 32'h11);
            check("alt_data_b1", 1, {24'd0, fd[1]},
                  (i % 2 == 1) ? 32'h22 : 32'h11);
            nxt();
        end
        mid();
        nxt();
        check("b1_acc1_pre_rst", 1, {31'd0, a1[1]}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_en", 0, {30'd0, en}, 32'd0);
        check("rst_mid_gnt", 0, {28'd0, g0, g1}, 32'd0);
        check("rst_mid_data", 0, {16'd0, fd[0], fd[1]}, 32'd0);
        nxt();
        rst = 1'b0;

        // single requester, 10 beats
        req_0 = 1'b1; req_1 = 1'b0; data_0 = 8'h30;
        mid();
        nxt();
        for (int i = 0; i < 10; i++) begin
            data_0 = 8'(8'h30 + i);
            mid();
            check("single_en", 0, {30'd0, en}, 32'd3);
            check("single_gnt0", 0, {31'd0, g0[0]}, 32'd1);
            check("single_data", 0, {24'd0, fd[0]}, 32'h30 + i);
            nxt();
        end

        // full stall in OWN1 after 2 beats
        pulse_rst();
        req_0 = 1'b0; req_1 = 1'b1; data_1 = 8'h5A;
        mid();
        nxt();
        for (int i = 0; i < 2; i++) begin
            mid();
            check("stall_pre_acc1", 0, {31'd0, a1[0]}, 32'd1);
            nxt();
        end
        fifo_full = 1'b1; req_0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mid();
            check("stall_gnt1", 0, {31'd0, g1[0]}, 32'd1);
            check("stall_no_acc", 0, {30'd0, a1}, 32'd0);
            nxt();
        end
        fifo_full = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mid();
            check("stall_post_acc1", 0, {31'd0, a1[0]}, 32'd1);
            nxt();
        end
        mid();
        check("stall_handover", 0, {30'd0, g0[0], g1[0]}, 32'd2);
`ifdef SYN_FIFO_WR_ARB_STALL_CNT_EN
        check("stall_cnt5", 0, {16'd0, sc[0]}, 32'd5);
`endif
        nxt();

        // early release after one beat
        pulse_rst();
        req_0 = 1'b1; req_1 = 1'b1;
        mid();
        nxt();
        mid();
        check("early_acc0", 0, {31'd0, a0[0]}, 32'd1);
        nxt();
        req_0 = 1'b0;
        mid();
        check("early_drop", 0, {30'd0, g0[0], en[0]}, 32'd2);
        nxt();
        for (int i = 0; i < 4; i++) begin
            mid();
            check("early_own1", 0, {30'd0, g1[0], a1[0]}, 32'd3);
            nxt();
            req_0 = 1'b1;
        end
        mid();
        check("early_back0", 0, {31'd0, g0[0]}, 32'd1);
        nxt();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            req_0     = ($urandom_range(0, 99) < 70);
            req_1     = ($urandom_range(0, 99) < 60);
            fifo_full = ($urandom_range(0, 99) < ((i / 500) % 2 ? 40 : 10));
            data_0    = 8'($urandom);
            data_1    = 8'($urandom);
            nxt();
        end
        rst = 1'b0;
        mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/syn_fifo_wr_arb.md
Name: syn_fifo_wr_arb

Overview:
- Round-robin write-port arbiter that shares one synchronous single-clock FIFO between two producers.
- Drives the FIFO write chip select, write enable and write data.
- Grants ownership in bursts of up to BURST_LEN beats.
- Stalls the owning producer while the FIFO reports full.
- Sits between the producer blocks and the FIFO write port; the read side is untouched.

Parameters:
- DATA_WIDTH, 8, width of the producer data and FIFO data.
- BURST_LEN, 4, maximum beats per grant; legal range 1..255.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- req_0  input  1  producer 0 has data on data_0; held until its beats are accepted.
- data_0  input  DATA_WIDTH  producer 0 write data.
- req_1  input  1  producer 1 request.
- data_1  input  DATA_WIDTH  producer 1 write data.
- fifo_full  input  1  FIFO full flag.
- gnt_0  output  1  producer 0 owns the write port (registered).
- gnt_1  output  1  producer 1 owns the write port (registered).
- acc_0  output  1  data_0 accepted this cycle (combinational).
- acc_1  output  1  data_1 accepted this cycle (combinational).
- fifo_wr_cs  output  1  FIFO write chip select.
- fifo_wr_en  output  1  FIFO write enable.
- fifo_data  output  DATA_WIDTH  FIFO write data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE; gnt_0=gnt_1=0; beat_cnt (8 bit)=0.
  - last_owner=1, so req_0 wins the first arbitration.
  - acc_x, fifo_wr_cs and fifo_wr_en are 0 and fifo_data is all zeros while rst=1.
- States: IDLE, OWN0, OWN1. gnt_x=1 exactly when state=OWNx.
- Accept rule: acc_x = gnt_x & req_x & !fifo_full & !rst.
- FIFO port:
  - fifo_wr_cs = fifo_wr_en = acc_0 | acc_1.
  - fifo_data = data_1 when gnt_1, else data_0.
  - At most one acc_x is high in any cycle.
- IDLE:
  - Any req present: go to OWNx on the next edge.
  - Both requesting: pick the one that is not last_owner.
  - Latency from req rising in IDLE to gnt is 1 cycle.
  - The first beat can be accepted in that same gnt cycle.
- In OWNx, beat_cnt increments on each acc_x.
- Release from OWNx on the clock edge where either:
  - (a) req_x=0, or
  - (b) acc_x=1 and beat_cnt==BURST_LEN-1 (burst exhausted).
- On release:
  - last_owner<=x and beat_cnt<=0.
  - If the other requester has req=1: go directly to OWN(other). No idle cycle, no gap in the write stream.
  - Else if (b) and req_x is still 1: re-grant OWNx with a fresh burst.
  - Else: go to IDLE.
- fifo_full=1 while owning:
  - No accept, ownership held, beat_cnt frozen.
  - Full never causes a release.
  - Release still occurs if req_x drops.
- A requester must not drop req_x mid-beat while not accepted. If it does, no write occurs and ownership releases.
- BURST_LEN=1: every accepted beat releases; with both requesting, grants strictly alternate.
- Reset asserted mid-burst:
  - Immediate return to the reset values.
  - Any beat in that cycle is not written (acc gated by rst).
- The arbiter never writes while fifo_full=1, so overflow protection is this block's responsibility.

Optional Feature:
- Macro: SYN_FIFO_WR_ARB_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [15:0], reset 0.
  - Increments each cycle where (gnt_0&req_0 | gnt_1&req_1) & fifo_full.
  - Saturates at 16'hFFFF; it never wraps.
  - Cleared only by rst.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset value check: assert rst for 3 cycles with req_0=req_1=1 -> gnt_0=gnt_1=0, fifo_wr_en=0. On the first cycle after release, state IDLE; the next edge gives gnt_0=1.
- Single requester burst: BURST_LEN=4, req_0 held high for 10 beats, fifo_full=0 -> 10 consecutive fifo_wr_en pulses with fifo_data=data_0. After every 4th beat the grant is re-granted to producer 0 and gnt_0 stays high throughout.
- Two-requester fairness: BURST_LEN=4, req_0=req_1=1 continuously -> write stream of 4×data_0, 4×data_1, 4×data_0, … with no idle cycle at the handovers.
- Full stall: during OWN1 after 2 beats, hold fifo_full=1 for 5 cycles -> acc_1=0 and gnt_1=1 throughout; after full drops exactly 2 more beats go out, then the grant moves to 0. With the macro defined, stall_cnt=5.
- Early release: req_0 drops after 1 beat while req_1=1 -> gnt_1 asserts on the next edge and beat_cnt restarts at 0.
- BURST_LEN=1 alternation plus reset mid-burst: grants alternate every beat. Asserting rst while acc_1=1 gives fifo_wr_en=0 in that cycle and all outputs at their reset values.
